// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one I2C master command port between NREQ requesters.
// Latches the winner's command, holds newd for the master, then waits for done or timeout.
module i2c_req_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned NEWD_HOLD = 48,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_wr,
  input  logic [NREQ*7-1:0] req_addr,
  input  logic [NREQ*8-1:0] req_wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rsp_done,
  output logic              rsp_err,
  output logic [7:0]        rsp_rdata,
  output logic              busy,
  output logic              m_newd,
  output logic              m_wr,
  output logic [6:0]        m_addr,
  output logic [7:0]        m_wdata,
  input  logic [7:0]        m_rdata,
  input  logic              m_done
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned HW = $clog2(NEWD_HOLD);
  localparam int unsigned TW = $clog2(TIMEOUT);

  localparam logic [IW-1:0] LAST_RST  = IW'(NREQ - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(NEWD_HOLD - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_COMPLETE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] last_gnt;
  logic [HW-1:0] hold_cnt;
  logic [TW-1:0] to_cnt;
  logic          done_q;
  logic          done_rise;

  logic          sel_valid;
  logic [IW-1:0] sel_idx;
  logic [IW:0]   cand;
  logic          sel_wr;
  logic [6:0]    sel_addr;
  logic [7:0]    sel_wdata;

  // Only a fresh rising edge counts; a level left over from the previous
  // transaction is absorbed into done_q while ISSUE is running.
  assign done_rise = m_done & ~done_q;

  // Search from last_gnt+1 upward with wrap; first set bit wins.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = {1'b0, last_gnt} + (IW+1)'(i);
      if (cand >= (IW+1)'(NREQ)) begin
        cand = cand - (IW+1)'(NREQ);
      end
      if (!sel_valid && req[cand[IW-1:0]]) begin
        sel_valid = 1'b1;
        sel_idx   = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (sel_idx == IW'(k)) begin
        sel_wr    = req_wr[k];
        sel_addr  = req_addr[7*k +: 7];
        sel_wdata = req_wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (sel_valid) state_nxt = S_ISSUE;
      S_ISSUE:    if (hold_cnt == HOLD_LAST) state_nxt = S_WAIT;
      S_WAIT:     if (done_rise || (to_cnt == TO_LAST)) state_nxt = S_COMPLETE;
      S_COMPLETE: state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt       <= '0;
      rsp_done  <= '0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      m_newd    <= 1'b0;
      m_wr      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      last_gnt  <= LAST_RST;
      hold_cnt  <= '0;
      to_cnt    <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= m_done;
      case (state)
        S_IDLE: begin
          if (sel_valid) begin
            gnt      <= NREQ'(1) << sel_idx;
            last_gnt <= sel_idx;
            m_wr     <= sel_wr;
            m_addr   <= sel_addr;
            m_wdata  <= sel_wdata;
            hold_cnt <= '0;
            to_cnt   <= '0;
            m_newd   <= 1'b1;
          end
        end
        S_ISSUE: begin
          hold_cnt <= hold_cnt + HW'(1);
          to_cnt   <= to_cnt + TW'(1);
          if (hold_cnt == HOLD_LAST) begin
            m_newd <= 1'b0;
          end
        end
        S_WAIT: begin
          to_cnt <= to_cnt + TW'(1);
          if (done_rise) begin
            rsp_done  <= gnt;
            rsp_err   <= 1'b0;
            rsp_rdata <= m_rdata;
          end else if (to_cnt == TO_LAST) begin
            rsp_done  <= gnt;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end
        end
        S_COMPLETE: begin
          gnt      <= '0;
          rsp_done <= '0;
          rsp_err  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
